// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared definitions for the five-stage MIPS pipeline control logic.
//   - T_W / tval_t : width and type of Tnew/Tuse timing values
//   - fwd_sel_e    : Decode forwarding mux encodings (FWD_RF, FWD_M, FWD_W, FWD_E)
//   - MULT_CYCLES_DEF / DIV_CYCLES_DEF : default mult/div busy lengths
//   - regMatch()   : "stage X writes register r" test (r0 never matches)
package mips_pipe_pkg;

    localparam int T_W = 2;
    typedef logic [T_W-1:0] tval_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic regMatch(input logic       regWrite,
                                      input logic [4:0] writeReg,
                                      input logic [4:0] srcReg);
        return regWrite && (writeReg == srcReg) && (srcReg != 5'd0);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter
// Busy countdown for the multi-cycle multiply/divide unit.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   md_startE  : mult/div instruction is in E this cycle
//   md_divE    : 1 = divide, 0 = multiply (valid with md_startE)
//   md_busy    : unit still computing (counter non-zero)
// A start seen while the counter is running is ignored; the pipeline never
// issues one because Decode is stalled while the unit is busy.
module md_busy_counter
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_startE,
    input  logic md_divE,
    output logic md_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_startE && (md_cnt == '0)) begin
            md_cnt <= md_divE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Central stall/forward scheduler for the five-stage MIPS pipeline.
// Compares Decode source registers and their Tuse with the Tnew/destination
// of the E, M and W pipeline registers to decide stall, E flush and Decode
// forwarding, and owns the mult/div busy countdown.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   rsD, rtD, Tuse_rsD, Tuse_rtD    : Decode sources and their Tuse
//   write_regE/M/W, regwriteE/M/W   : destination info per stage
//   Tnew_E, Tnew_M                  : cycles until E/M result exists
//   md_startE, md_divE, md_useD     : mult/div issue and HI/LO use
//   stallF, stallD, flushE          : pipeline register control
//   fwd_rsD, fwd_rtD                : 0 regfile, 1 M, 2 W, 3 E
//   md_busy                         : mult/div unit computing
//   stall_count                     : cumulative stall cycles, present only
//                                     when HAZARD_STALL_CNT_EN is defined
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [1:0] Tuse_rsD,
    input  logic [1:0] Tuse_rtD,
    input  logic [4:0] write_regE,
    input  logic [4:0] write_regM,
    input  logic [4:0] write_regW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic [1:0] Tnew_E,
    input  logic [1:0] Tnew_M,
    input  logic       md_startE,
    input  logic       md_divE,
    input  logic       md_useD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    logic     matchEs, matchMs, matchWs;
    logic     matchEt, matchMt, matchWt;
    logic     dataStall;
    logic     mdStall;
    logic     stall;
    fwd_sel_e fwdRs, fwdRt;

    // Priority E > M > W; a producer only forwards once its value exists.
    function automatic fwd_sel_e fwdSel(input logic  mE,
                                        input logic  mM,
                                        input logic  mW,
                                        input tval_t tnewE,
                                        input tval_t tnewM);
        if (mE && (tnewE == '0))      return FWD_E;
        else if (mM && (tnewM == '0)) return FWD_M;
        else if (mW)                  return FWD_W;
        else                          return FWD_RF;
    endfunction

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .md_startE(md_startE),
        .md_divE  (md_divE),
        .md_busy  (md_busy)
    );

    always_comb begin
        matchEs = regMatch(regwriteE, write_regE, rsD);
        matchMs = regMatch(regwriteM, write_regM, rsD);
        matchWs = regMatch(regwriteW, write_regW, rsD);
        matchEt = regMatch(regwriteE, write_regE, rtD);
        matchMt = regMatch(regwriteM, write_regM, rtD);
        matchWt = regMatch(regwriteW, write_regW, rtD);

        // Stall when the consumer needs the value before the producer has it.
        dataStall = (matchEs && (Tuse_rsD < Tnew_E)) || (matchMs && (Tuse_rsD < Tnew_M)) ||
                    (matchEt && (Tuse_rtD < Tnew_E)) || (matchMt && (Tuse_rtD < Tnew_M));

        // md_startE covers the issue cycle, before the counter has loaded.
        mdStall = md_useD && (md_busy || md_startE);
        stall   = dataStall || mdStall;

        fwdRs = fwdSel(matchEs, matchMs, matchWs, Tnew_E, Tnew_M);
        fwdRt = fwdSel(matchEt, matchMt, matchWt, Tnew_E, Tnew_M);

        stallF  = stall;
        stallD  = stall;
        flushE  = stall;
        fwd_rsD = fwdRs;
        fwd_rtD = fwdRt;

        // Hold a bubble in E and neutral forwarding while in reset.
        if (reset) begin
            stallF  = 1'b0;
            stallD  = 1'b0;
            flushE  = 1'b1;
            fwd_rsD = FWD_RF;
            fwd_rtD = FWD_RF;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stall) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_count = stallCnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD;
    logic [1:0] Tuse_rsD, Tuse_rtD;
    logic [4:0] write_regE, write_regM, write_regW;
    logic       regwriteE, regwriteM, regwriteW;
    logic [1:0] Tnew_E, Tnew_M;
    logic       md_startE, md_divE, md_useD;
    logic       stallF, stallD, flushE;
    logic [1:0] fwd_rsD, fwd_rtD;
    logic       md_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .Tuse_rsD  (Tuse_rsD),
        .Tuse_rtD  (Tuse_rtD),
        .write_regE(write_regE),
        .write_regM(write_regM),
        .write_regW(write_regW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .Tnew_E    (Tnew_E),
        .Tnew_M    (Tnew_M),
        .md_startE (md_startE),
        .md_divE   (md_divE),
        .md_useD   (md_useD),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushE    (flushE),
        .fwd_rsD   (fwd_rsD),
        .fwd_rtD   (fwd_rtD),
        .md_busy   (md_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearIn();
        rsD = 5'd0; rtD = 5'd0; Tuse_rsD = 2'd0; Tuse_rtD = 2'd0;
        write_regE = 5'd0; write_regM = 5'd0; write_regW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        Tnew_E = 2'd0; Tnew_M = 2'd0;
        md_startE = 1'b0; md_divE = 1'b0; md_useD = 1'b0;
    endtask

    // Step to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chkStall(input string tag, input logic exp);
        #1;
        chk({tag, "_stallF"}, {31'd0, stallF}, {31'd0, exp});
        chk({tag, "_stallD"}, {31'd0, stallD}, {31'd0, exp});
        chk({tag, "_flushE"}, {31'd0, flushE}, {31'd0, exp});
    endtask

    // Issue a mult/div at cycle t with a HI/LO consumer held in D; stall must
    // cover t..t+n and release at t+n+1.
    task automatic mdRun(input string tag, input logic isDiv, input int n);
        nextCycle();
        clearIn();
        md_useD = 1'b1; md_startE = 1'b1; md_divE = isDiv;
        chkStall({tag, "_issue"}, 1'b1);
        chk({tag, "_busy_issue"}, {31'd0, md_busy}, 32'd0);
        for (int k = 1; k <= n; k++) begin
            nextCycle();
            md_startE = 1'b0;
            #1;
            chk($sformatf("%s_stall_t%0d", tag, k), {31'd0, stallD}, 32'd1);
            chk($sformatf("%s_busy_t%0d", tag, k), {31'd0, md_busy}, 32'd1);
        end
        nextCycle();
        chkStall({tag, "_release"}, 1'b0);
        chk({tag, "_busy_release"}, {31'd0, md_busy}, 32'd0);
    endtask

    initial begin
        clearIn();
        reset = 1'b1;
        // Reset state: bubble in E, no stall, neutral forwarding.
        rsD = 5'd5; regwriteW = 1'b1; write_regW = 5'd5;
        nextCycle();
        #1;
        chk("rst_flushE", {31'd0, flushE}, 32'd1);
        chk("rst_stallF", {31'd0, stallF}, 32'd0);
        chk("rst_fwd_rs", {30'd0, fwd_rsD}, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        reset = 1'b0;
        clearIn();
        nextCycle();

        // E-stage load-use: Tuse 0 < Tnew_E 2.
        rsD = 5'd8; Tuse_rsD = 2'd0; write_regE = 5'd8; regwriteE = 1'b1; Tnew_E = 2'd2;
        chkStall("e_stall", 1'b1);
        chk("e_stall_fwd", {30'd0, fwd_rsD}, 32'd0);
        // Register 0 never creates a hazard.
        rsD = 5'd0; write_regE = 5'd0;
        chkStall("r0_nostall", 1'b0);

        // M producer ready: forward from M, no stall.
        clearIn();
        rtD = 5'd9; Tuse_rtD = 2'd1; write_regM = 5'd9; regwriteM = 1'b1; Tnew_M = 2'd0;
        chkStall("m_fwd", 1'b0);
        chk("m_fwd_rt", {30'd0, fwd_rtD}, 32'd1);
        // E also writes 9 and is ready: E wins.
        write_regE = 5'd9; regwriteE = 1'b1; Tnew_E = 2'd0;
        #1;
        chk("e_over_m_rt", {30'd0, fwd_rtD}, 32'd3);

        // M-stage stall: Tuse 0 < Tnew_M 1.
        clearIn();
        rtD = 5'd12; Tuse_rtD = 2'd0; write_regM = 5'd12; regwriteM = 1'b1; Tnew_M = 2'd1;
        chkStall("m_stall", 1'b1);

        // W only.
        clearIn();
        rsD = 5'd5; write_regW = 5'd5; regwriteW = 1'b1;
        #1;
        chk("w_fwd_rs", {30'd0, fwd_rsD}, 32'd2);
        regwriteW = 1'b0;
        #1;
        chk("w_off_rs", {30'd0, fwd_rsD}, 32'd0);

        // Tnew = 3 boundary: stall at Tuse 2, not at Tuse 3.
        clearIn();
        rsD = 5'd4; Tuse_rsD = 2'd2; write_regE = 5'd4; regwriteE = 1'b1; Tnew_E = 2'd3;
        chkStall("tnew3_stall", 1'b1);
        Tuse_rsD = 2'd3;
        chkStall("tnew3_nostall", 1'b0);

        // Multiply and divide busy windows.
        mdRun("mult", 1'b0, 5);
        mdRun("div", 1'b1, 10);

        // Reset at cycle 3 of a divide aborts it.
        nextCycle();
        clearIn();
        md_startE = 1'b1; md_divE = 1'b1;
        nextCycle();
        md_startE = 1'b0;
        nextCycle();
        nextCycle();
        #1;
        chk("div_mid_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        md_useD = 1'b1;
        rsD = 5'd7; write_regM = 5'd7; regwriteM = 1'b1; Tnew_M = 2'd0;
        #1;
        chk("rst_mid_flushE", {31'd0, flushE}, 32'd1);
        chk("rst_mid_stallD", {31'd0, stallD}, 32'd0);
        chk("rst_mid_fwd", {30'd0, fwd_rsD}, 32'd0);
        nextCycle();
        reset = 1'b0;
        chkStall("rst_mid_after", 1'b0);
        chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_mid_fwd_after", {30'd0, fwd_rsD}, 32'd1);

`ifdef HAZARD_STALL_CNT_EN
        clearIn();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        chk("cnt_rst", stall_count, 32'd0);
        rsD = 5'd8; write_regE = 5'd8; regwriteE = 1'b1; Tnew_E = 2'd2;
        for (int k = 0; k < 7; k++) nextCycle();
        clearIn();
        nextCycle();
        chk("cnt_seven", stall_count, 32'd7);
        dut.stallCnt <= 32'hFFFF_FFFE;
        #1;
        rsD = 5'd8; write_regE = 5'd8; regwriteE = 1'b1; Tnew_E = 2'd2;
        nextCycle();
        chk("cnt_max", stall_count, 32'hFFFF_FFFF);
        nextCycle();
        chk("cnt_wrap", stall_count, 32'd0);
        clearIn();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
